// File: rtl/pipelined_multiply_n.sv
// Iterative radix-2^STEP shift-add multiplier with valid/ready handshakes on both sides.
// Produces the full 2*WIDTH-bit product (unsigned or two's-complement) plus a fits-in-WIDTH flag.
module pipelined_multiply_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic             overflow
);

    localparam int unsigned N    = WIDTH / STEP;
    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   prod_lo_q, prod_lo_d;
    logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] partial, acc_sum, result;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_ovf;

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        mode_d      = mode_q;
        prod_lo_d   = prod_lo_q;
        prod_hi_d   = prod_hi_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        // Magnitudes are taken as unsigned WIDTH-bit values, so the most-negative operand
        // maps to 2^(WIDTH-1) exactly.
        mag_a = (signed_mode && A[WIDTH-1]) ? -A : A;
        mag_b = (signed_mode && B[WIDTH-1]) ? -B : B;

        partial = '0;
        for (int i = 0; i < int'(STEP); i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
        acc_sum = acc_q + partial;
        result  = sign_q ? -acc_sum : acc_sum;
        res_hi  = result[2*WIDTH-1:WIDTH];
        res_lo  = result[WIDTH-1:0];
        res_ovf = mode_q ? (res_hi != {WIDTH{res_lo[WIDTH-1]}}) : (res_hi != '0);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    sign_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                    mode_d   = signed_mode;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    prod_hi_d   = res_hi;
                    prod_lo_d   = res_lo;
                    ovf_d       = res_ovf;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            mode_q      <= 1'b0;
            prod_lo_q   <= '0;
            prod_hi_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            mode_q      <= mode_d;
            prod_lo_q   <= prod_lo_d;
            prod_hi_q   <= prod_hi_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = out_valid_q;
    assign product_lo = prod_lo_q;
    assign product_hi = prod_hi_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pipelined_multiply_n.sv
// Randomised bench for pipelined_multiply_n: three configurations (16/2, 8/1, 32/4) checked
// against an integer-arithmetic reference model, plus directed handshake and reset cases.
module tb_pipelined_multiply_n;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        iv0, ir0, sm0, ov0, or0, of0;
    logic [15:0] a0, b0, lo0, hi0;
    logic        iv1, ir1, sm1, ov1, or1, of1;
    logic [7:0]  a1, b1, lo1, hi1;
    logic        iv2, ir2, sm2, ov2, or2, of2;
    logic [31:0] a2, b2, lo2, hi2;

    pipelined_multiply_n #(.WIDTH(16), .STEP(2)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .signed_mode(sm0), .out_valid(ov0), .out_ready(or0), .product_lo(lo0),
        .product_hi(hi0), .overflow(of0)
    );
    pipelined_multiply_n #(.WIDTH(8), .STEP(1)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .signed_mode(sm1), .out_valid(ov1), .out_ready(or1), .product_lo(lo1),
        .product_hi(hi1), .overflow(of1)
    );
    pipelined_multiply_n #(.WIDTH(32), .STEP(4)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .signed_mode(sm2), .out_valid(ov2), .out_ready(or2), .product_lo(lo2),
        .product_hi(hi2), .overflow(of2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wd(input int inst);
        case (inst)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int stp(input int inst);
        case (inst)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return m;
    endfunction

    // Reference model: the operands as plain integers, multiplied.
    function automatic longint opval(input int w, input logic [31:0] x, input logic sm);
        longint v;
        v = longint'({32'd0, x & wmask(w)});
        if (sm && x[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic logic [63:0] model_prod(input int w, input logic [31:0] a,
                                               input logic [31:0] b, input logic sm);
        logic [63:0] p;
        p = opval(w, a, sm) * opval(w, b, sm);
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    function automatic logic model_ovf(input int w, input logic [31:0] a,
                                       input logic [31:0] b, input logic sm);
        longint p, lim;
        logic [63:0] up;
        if (!sm) begin
            up = {32'd0, a & wmask(w)} * {32'd0, b & wmask(w)};
            return (up >> w) != 64'd0;
        end
        p   = opval(w, a, 1'b1) * opval(w, b, 1'b1);
        lim = longint'(1) << (w - 1);
        return (p < -lim) || (p >= lim);
    endfunction

    task automatic drive(input int inst, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic sm);
        case (inst)
            0: begin iv0 = v; a0 = a[15:0]; b0 = b[15:0]; sm0 = sm; end
            1: begin iv1 = v; a1 = a[7:0];  b1 = b[7:0];  sm1 = sm; end
            default: begin iv2 = v; a2 = a; b2 = b; sm2 = sm; end
        endcase
    endtask

    task automatic set_ordy(input int inst, input logic r);
        case (inst)
            0:       or0 = r;
            1:       or1 = r;
            default: or2 = r;
        endcase
    endtask

    task automatic sample(input int inst, output logic irdy, output logic ovld,
                          output logic [63:0] prod, output logic ovf);
        case (inst)
            0: begin irdy = ir0; ovld = ov0; prod = {32'd0, hi0, lo0}; ovf = of0; end
            1: begin irdy = ir1; ovld = ov1; prod = {48'd0, hi1, lo1}; ovf = of1; end
            default: begin irdy = ir2; ovld = ov2; prod = {hi2, lo2}; ovf = of2; end
        endcase
    endtask

    task automatic check_reset_vals(input int inst);
        logic irdy, ovld, ovf;
        logic [63:0] prod;
        sample(inst, irdy, ovld, prod, ovf);
        check_eq("rst_in_ready", 64'(irdy), 64'd1);
        check_eq("rst_out_valid", 64'(ovld), 64'd0);
        check_eq("rst_product", prod, 64'd0);
        check_eq("rst_overflow", 64'(ovf), 64'd0);
    endtask

    // Issue one operation from idle, check latency/result, stall, then complete the handshake.
    task automatic run_op(input int inst, input logic [31:0] a, input logic [31:0] b,
                          input logic sm, input int stall, input string tag);
        int w, n, cyc;
        logic irdy, ovld, ovf;
        logic [63:0] prod, exp_p;
        logic exp_o;
        w     = wd(inst);
        n     = w / stp(inst);
        exp_p = model_prod(w, a, b, sm);
        exp_o = model_ovf(w, a, b, sm);
        set_ordy(inst, 1'b0);
        drive(inst, 1'b1, a, b, sm);
        sample(inst, irdy, ovld, prod, ovf);
        check_eq({tag, "_accept_ready"}, 64'(irdy), 64'd1);
        @(posedge clk);
        #1;
        drive(inst, 1'b0, $urandom, $urandom, 1'($urandom));
        sample(inst, irdy, ovld, prod, ovf);
        check_eq({tag, "_busy_ready"}, 64'(irdy), 64'd0);
        cyc  = 0;
        ovld = 1'b0;
        while (!ovld && cyc < n + 4) begin
            set_ordy(inst, 1'($urandom));
            @(posedge clk);
            #1;
            cyc++;
            sample(inst, irdy, ovld, prod, ovf);
        end
        check_eq({tag, "_latency"}, 64'(cyc), 64'(n));
        check_eq({tag, "_product"}, prod, exp_p);
        check_eq({tag, "_overflow"}, 64'(ovf), 64'(exp_o));
        for (int s = 0; s < stall; s++) begin
            set_ordy(inst, 1'b0);
            @(posedge clk);
            #1;
            sample(inst, irdy, ovld, prod, ovf);
            check_eq({tag, "_stall_valid"}, 64'(ovld), 64'd1);
            check_eq({tag, "_stall_product"}, prod, exp_p);
            check_eq({tag, "_stall_overflow"}, 64'(ovf), 64'(exp_o));
            check_eq({tag, "_stall_ready"}, 64'(irdy), 64'd0);
        end
        set_ordy(inst, 1'b1);
        @(posedge clk);
        #1;
        set_ordy(inst, 1'b0);
        sample(inst, irdy, ovld, prod, ovf);
        check_eq({tag, "_post_valid"}, 64'(ovld), 64'd0);
        check_eq({tag, "_post_ready"}, 64'(irdy), 64'd1);
    endtask

    function automatic logic [31:0] pick_operand(input int w);
        logic [31:0] x;
        case ($urandom_range(0, 7))
            0:       x = 32'd0;
            1:       x = wmask(w);
            2:       x = 32'd1 << (w - 1);
            default: x = $urandom & wmask(w);
        endcase
        return x;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic irdy, ovld, ovf;
        logic [63:0] prod;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 32'd0, 32'd0, 1'b0);
            set_ordy(i, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset_vals(i);
        reset = 1'b0;

        run_op(0, 32'hFFFF, 32'hFFFF, 1'b0, 0, "uns_ffff");
        check_eq("uns_ffff_exact", model_prod(16, 32'hFFFF, 32'hFFFF, 1'b0), 64'hFFFE_0001);
        run_op(0, 32'hFFFD, 32'h0005, 1'b1, 0, "sgn_m3x5");
        run_op(0, 32'h8000, 32'h8000, 1'b1, 0, "sgn_minmin");
        run_op(0, 32'h00FF, 32'h0101, 1'b0, 5, "uns_stall");

        // Abort an operation in its fourth RUN cycle; operands shown during reset are dropped.
        drive(0, 1'b1, 32'h1234, 32'h5678, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(0, 1'b1, 32'h0009, 32'h0009, 1'b0);
        @(posedge clk);
        #1;
        check_reset_vals(0);
        reset = 1'b0;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            set_ordy(0, 1'($urandom));
            @(posedge clk);
            #1;
            sample(0, irdy, ovld, prod, ovf);
            check_eq("abort_no_valid", 64'(ovld), 64'd0);
            check_eq("abort_idle_ready", 64'(irdy), 64'd1);
        end
        set_ordy(0, 1'b0);
        run_op(0, 32'd7, 32'd6, 1'b0, 0, "after_abort");

        for (int inst = 0; inst < 3; inst++) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 1000; k++) begin
                    run_op(inst, pick_operand(wd(inst)), pick_operand(wd(inst)), 1'(m),
                           ($urandom_range(0, 7) == 0) ? 2 : 0, $sformatf("rnd_w%0d", wd(inst)));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
